seq_sm_multiplier: RTL
======================

Name: seq_sm_multiplier

Overview:
- Sequential shift-and-add multiplier for sign-magnitude operands, parametrised in magnitude width N.
- Processes one multiplier bit per clock under a start/busy/done handshake, so one adder serves any width.
- Adds zero-sign normalisation: a zero product is never reported as negative zero.
- Used wherever the combinational sign-magnitude multiplier is too large or too slow at wider widths.

Parameters:
- N, 8, magnitude bits per operand; operands are N+1 bits wide and prod is 2N+1 bits wide; N >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to multiply x by y; sampled on the rising edge.
- x  input  N+1  multiplicand; bit N is the sign (1 = negative), bits N-1:0 are the magnitude.
- y  input  N+1  multiplier, same format as x.
- busy  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse; high only in the DONE state.
- prod  output  2N+1  result; bit 2N is the sign, bits 2N-1:0 are the magnitude; holds its value until the next result.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE; busy = 0; done = 0; prod = 0.
  - All internal registers (accumulator, shifted multiplicand, multiplier shift register, counter, sign) = 0.
- States: IDLE, RUN, DONE.
- start is accepted in IDLE or DONE. At the accepting edge:
  - mcand (2N bits) <= zero-extended x[N-1:0].
  - mplier (N bits) <= y[N-1:0].
  - acc <= 0; cnt <= 0; sgn <= x[N] ^ y[N].
  - state <= RUN.
  - Acceptance in DONE gives back-to-back operation with no idle cycle.
- start while in RUN is ignored. Operands are not re-sampled, and no queueing occurs.
- RUN, at each edge:
  - If mplier[0] = 1, acc <= acc + mcand; the addition is 2N bits wide and cannot overflow.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - The counter is clog2(N+1) bits wide.
- On the RUN edge where cnt = N-1 (the N-th RUN edge):
  - state <= DONE.
  - prod <= {sgn_final, acc_next}, where acc_next is the accumulator value including this edge's add.
  - sgn_final = sgn if acc_next != 0, else 0 (zero normalisation).
- DONE:
  - done = 1 for exactly one cycle.
  - Next edge: RUN if start = 1, else IDLE.
- IDLE: holds; done = 0.
- Latency: start sampled at edge 0, RUN at edges 1..N, done and the new prod are visible after edge N (N cycles).
  - Throughput is one result per N+1 cycles.
- Output timing:
  - busy and done are decoded from the state register, and prod is registered; no combinational path from inputs to outputs.
  - prod changes only on the edge entering DONE, or on reset.
- x and y may change freely after the accepting edge without affecting the result in progress.
- Reset asserted mid-RUN:
  - Immediate return to IDLE with prod = 0 and done = 0.
  - No done pulse is emitted for the aborted operation.
  - After rst_n rises, the first start is processed normally.
- Operand edge cases:
  - Magnitude 0 on either operand gives prod = 0 with sign 0, including -0 inputs.
  - Maximum magnitudes give (2^N-1)^2 exactly.

Test Plan:
- N=8: reset, then start with x=+5 (9'h005), y=+3 (9'h003) -> busy for 8 cycles, done 8 cycles after the start edge, prod = 17'h0000F; prod holds after done falls.
- N=8: x=-7 (9'h107), y=+6 (9'h006) -> prod = 17'h1002A; then x=-255 (9'h1FF), y=-255 (9'h1FF) -> prod = 17'h0FE01; then x=+255, y=-255 -> prod = 17'h1FE01.
- N=8: x=-0 (9'h100), y=+5; then x=-9, y=0 -> prod = 17'h00000 both times (sign bit 0), done pulses normally.
- N=8: start held high continuously, operands changed every cycle -> one result per 9 cycles using the operands sampled at each accepting edge; start pulses during RUN have no effect; done is never high for two consecutive cycles.
- N=8: start x=+12, y=+10, assert rst_n=0 at RUN cycle 4 -> busy=0, done=0, prod=0 immediately; release, start x=+12, y=+10 -> prod = 17'h00078 with no spurious earlier done.
- N=4 and N=16 builds: x=-15 * y=+15 -> prod = 9'h1E1 (N=4); x=+65535 * y=+65535 -> prod = 33'h0FFFE0001 (N=16); latency equals N cycles in each build.

Source files
------------

// File: rtl/seq_sm_multiplier.sv
// -----------------------------------------------------------------------------
// seq_sm_multiplier
//
// Sequential shift-and-add multiplier for sign-magnitude operands. One
// multiplier bit is consumed per clock, so a single 2N-bit adder serves any
// width. A zero product is always reported with a positive sign.
//
// Handshake: start is accepted on a rising edge while the block is IDLE or
// DONE (busy = 0). start during RUN is ignored. done pulses for exactly one
// cycle when prod has been updated. Accepting start in DONE gives back-to-back
// operation with no idle cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request to multiply x by y
//   x, y      N+1 bit sign-magnitude operands (bit N = sign, 1 = negative)
//   busy      high while the multiply is in progress (RUN)
//   done      one-cycle pulse, high only in DONE
//   prod      2N+1 bit sign-magnitude result, held until the next result
//   state_dbg current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
// -----------------------------------------------------------------------------
module seq_sm_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N:0]     x,
  input  logic [N:0]     y,
  output logic           busy,
  output logic           done,
  output logic [2*N:0]   prod,
  output logic [1:0]     state_dbg
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  mcand;
  logic [N-1:0]    mplier;
  logic [CW-1:0]   cnt;
  logic            sgn;
  logic [2*N-1:0]  acc_next;

  // Partial product for this edge; the 2N-bit sum of N-bit magnitudes
  // cannot overflow.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      prod   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= {{N{1'b0}}, x[N-1:0]};
            mplier <= y[N-1:0];
            acc    <= '0;
            cnt    <= '0;
            sgn    <= x[N] ^ y[N];
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            // Zero normalisation: a zero magnitude never carries a minus sign.
            prod  <= {sgn & (acc_next != '0), acc_next};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule
